// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: one-hot T1..T6 ring counter with a Moore decode of (T-state, opcode) into the bus control word.
// Define SAP_VAR_CYCLE_EN to end each instruction right after its last active T-state instead of always running six.
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] ir_opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic       hlt,
  output logic       instr_done
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state;
  tstate_e state_next;
  tstate_e last_t;
  logic    hlt_q;
  logic    hlt_next;
  logic    halt_now;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= T1;
      hlt_q <= 1'b0;
    end else begin
      state <= state_next;
      hlt_q <= hlt_next;
    end
  end

`ifdef SAP_VAR_CYCLE_EN
  // Undefined opcodes end after fetch; the IR holds the opcode by T3 in this mode.
  always_comb begin
    last_t = T6;
    case (ir_opcode)
      OP_LDA:         last_t = T5;
      OP_ADD, OP_SUB: last_t = T6;
      OP_OUT:         last_t = T4;
      OP_HLT:         last_t = T6;
      default:        last_t = T3;
    endcase
  end
`else
  always_comb begin
    last_t = T6;
  end
`endif

  assign halt_now = (state == T4) && (ir_opcode == OP_HLT);

  always_comb begin
    state_next = T1;
    hlt_next   = hlt_q;
    case (state)
      T1, T2, T3, T4, T5, T6: begin
        if (hlt_q || halt_now) begin
          state_next = state;
          hlt_next   = 1'b1;
        end else if (state == last_t) begin
          state_next = T1;
        end else begin
          state_next = tstate_e'({state[4:0], 1'b0});
        end
      end
      default: state_next = T1;
    endcase
  end

  // Lines idle at their inactive level while in reset or halted.
  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    ei_n = 1'b1;
    la_n = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    lb_n = 1'b1;
    lo_n = 1'b1;
    if (clr_n && !hlt_q) begin
      case (state)
        T1: begin
          ep   = 1'b1;
          lm_n = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_n = 1'b0;
          li_n = 1'b0;
        end
        T4: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei_n = 1'b0;
              lm_n = 1'b0;
            end
            OP_OUT: begin
              ea   = 1'b1;
              lo_n = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (ir_opcode)
            OP_LDA: begin
              ce_n = 1'b0;
              la_n = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ce_n = 1'b0;
              lb_n = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          case (ir_opcode)
            OP_ADD: begin
              eu   = 1'b1;
              la_n = 1'b0;
            end
            OP_SUB: begin
              eu   = 1'b1;
              su   = 1'b1;
              la_n = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign t_state    = state;
  assign hlt        = hlt_q | halt_now;
  assign instr_done = clr_n && !hlt && (state == last_t);

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench for sap_controller_sequencer: directed scenarios plus random opcode streams against a step-count model.
// Define SAP_VAR_CYCLE_EN here too when building the variable-length configuration.
module tb_sap_controller_sequencer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] ir_opcode;
  logic [5:0] t_state;
  logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  logic       hlt, instr_done;

  int total = 0;
  int bad   = 0;

  int         step;
  logic       halted;
  logic [3:0] cur_op;

  localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
  localparam int B_LA = 5, B_EA = 4, B_SU = 3, B_EU = 2, B_LB = 1, B_LO = 0;

  sap_controller_sequencer dut (
    .clk(clk), .clr_n(clr_n), .ir_opcode(ir_opcode), .t_state(t_state),
    .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
    .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
    .hlt(hlt), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Number of T-states an instruction occupies before the ring returns to T1.
  function automatic int instr_len(input logic [3:0] op);
`ifdef SAP_VAR_CYCLE_EN
    case (op)
      4'h0:       return 5;
      4'h1, 4'h2: return 6;
      4'hE:       return 4;
      4'hF:       return 6;
      default:    return 3;
    endcase
`else
    return 6;
`endif
  endfunction

  // Set of asserted controls for a given opcode and T-step, written as fetch + execute rules.
  function automatic logic [11:0] exp_ctrl(input logic [3:0] op, input int st);
    logic [11:0] c;
    c = '0;
    if (st == 1) begin c[B_EP] = 1'b1; c[B_LM] = 1'b1; end
    if (st == 2) c[B_CP] = 1'b1;
    if (st == 3) begin c[B_CE] = 1'b1; c[B_LI] = 1'b1; end
    if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
      if (st == 4) begin c[B_EI] = 1'b1; c[B_LM] = 1'b1; end
      if (st == 5) begin
        c[B_CE] = 1'b1;
        if (op == 4'h0) c[B_LA] = 1'b1;
        else            c[B_LB] = 1'b1;
      end
      if (st == 6 && op != 4'h0) begin
        c[B_EU] = 1'b1;
        c[B_LA] = 1'b1;
        c[B_SU] = (op == 4'h2);
      end
    end
    if (op == 4'hE && st == 4) begin c[B_EA] = 1'b1; c[B_LO] = 1'b1; end
    return c;
  endfunction

  function automatic logic model_hlt();
    return clr_n && (halted || (step == 4 && cur_op == 4'hF));
  endfunction

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d op=%0h: observed=%0h expected=%0h", tag, step, cur_op, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [11:0] obs_c;
    logic [11:0] e_c;
    logic [5:0]  e_t;
    logic        e_h;
    logic        e_d;
    e_h   = model_hlt();
    e_t   = 6'(1 << (step - 1));
    e_c   = (clr_n && !e_h) ? exp_ctrl(cur_op, step) : 12'h000;
    e_d   = clr_n && !e_h && (step == instr_len(cur_op));
    obs_c = {cp, ep, ~lm_n, ~ce_n, ~li_n, ~ei_n, ~la_n, ea, su, eu, ~lb_n, ~lo_n};
    check_val("t_state", {6'b0, t_state}, {6'b0, e_t});
    check_val("ctrl", obs_c, e_c);
    check_val("hlt", {11'b0, hlt}, {11'b0, e_h});
    check_val("instr_done", {11'b0, instr_done}, {11'b0, e_d});
  endtask

  // One T-state: drive, check away from the edge, then account for the coming posedge.
  task automatic apply_stimulus();
    ir_opcode = cur_op;
    #1;
    check_output();
    if (model_hlt()) halted = 1'b1;
    else if (step == instr_len(cur_op)) step = 1;
    else step++;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [3:0] op);
    cur_op = op;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus();
      if (step == 1 || halted) break;
    end
  endtask

  task automatic async_reset_pulse();
    #2 clr_n = 1'b0;
    step   = 1;
    halted = 1'b0;
    #1;
    check_output();
    @(negedge clk);
    check_output();
    clr_n = 1'b1;
  endtask

  initial begin
    logic [3:0] op;
    clr_n     = 1'b0;
    ir_opcode = 4'h0;
    cur_op    = 4'h0;
    step      = 1;
    halted    = 1'b0;
    @(negedge clk);
    #1 check_output();
    @(negedge clk);
    clr_n = 1'b1;

    $display("[TB] reset during T5 of ADD");
    cur_op = 4'h1;
    for (int i = 0; i < 4; i++) apply_stimulus();
    ir_opcode = cur_op;
    #1 check_output();
    async_reset_pulse();

    $display("[TB] directed LDA, SUB, undefined, OUT, ADD");
    run_instr(4'h0);
    run_instr(4'h2);
    run_instr(4'h7);
    run_instr(4'h0);
    run_instr(4'hE);
    run_instr(4'h0);
    run_instr(4'h1);

    $display("[TB] random opcode stream");
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF) op = 4'h2;
      run_instr(op);
    end

    $display("[TB] OUT then HLT, held for 22 cycles");
    run_instr(4'hE);
    run_instr(4'hF);
    for (int i = 0; i < 22; i++) apply_stimulus();
    async_reset_pulse();
    run_instr(4'h0);
    run_instr(4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
